// File: rtl/ps2_kbd_pkg.sv
// Shared scan-code constants, decoder state encoding and the Set-2 scan-to-ASCII lookup.
package ps2_kbd_pkg;

  localparam int unsigned SCAN_W = 8;
  localparam int unsigned CHAR_W = 7;

  localparam logic [SCAN_W-1:0] SC_BREAK  = 8'hF0;
  localparam logic [SCAN_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [SCAN_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [SCAN_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [SCAN_W-1:0] SC_CAPS   = 8'h58;
  localparam logic [SCAN_W-1:0] SC_ENTER  = 8'h5A;
  localparam logic [SCAN_W-1:0] SC_BKSP   = 8'h66;
  localparam logic [SCAN_W-1:0] SC_SPACE  = 8'h29;
  localparam logic [SCAN_W-1:0] SC_BAT    = 8'hAA;
  localparam logic [SCAN_W-1:0] SC_ACK    = 8'hFA;
  localparam logic [SCAN_W-1:0] SC_RESEND = 8'hFE;
  localparam logic [SCAN_W-1:0] SC_ERR0   = 8'h00;
  localparam logic [SCAN_W-1:0] SC_ERRF   = 8'hFF;

  localparam logic [CHAR_W-1:0] CH_CR  = 7'h0D;
  localparam logic [CHAR_W-1:0] CH_DEL = 7'h7F;
  localparam logic [CHAR_W-1:0] CH_SP  = 7'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } kbd_state_e;

  typedef struct packed {
    logic              hit;
    logic [CHAR_W-1:0] code;
  } kbd_char_t;

  // Keyboard housekeeping bytes that carry no key information outside a prefix.
  function automatic logic is_idle_noise(input logic [SCAN_W-1:0] scan);
    return (scan == SC_BAT) || (scan == SC_ACK) || (scan == SC_RESEND) ||
           (scan == SC_ERR0) || (scan == SC_ERRF);
  endfunction

  function automatic kbd_char_t scan_to_ascii(input logic [SCAN_W-1:0] scan,
                                              input logic upper, input logic sym);
    kbd_char_t   res;
    logic        is_letter;
    logic        is_digit;
    logic [4:0]  letter;
    logic [3:0]  digit;
    res       = '0;
    is_letter = 1'b0;
    is_digit  = 1'b0;
    letter    = '0;
    digit     = '0;
    case (scan)
      8'h1C: {is_letter, letter} = {1'b1, 5'd0};
      8'h32: {is_letter, letter} = {1'b1, 5'd1};
      8'h21: {is_letter, letter} = {1'b1, 5'd2};
      8'h23: {is_letter, letter} = {1'b1, 5'd3};
      8'h24: {is_letter, letter} = {1'b1, 5'd4};
      8'h2B: {is_letter, letter} = {1'b1, 5'd5};
      8'h34: {is_letter, letter} = {1'b1, 5'd6};
      8'h33: {is_letter, letter} = {1'b1, 5'd7};
      8'h43: {is_letter, letter} = {1'b1, 5'd8};
      8'h3B: {is_letter, letter} = {1'b1, 5'd9};
      8'h42: {is_letter, letter} = {1'b1, 5'd10};
      8'h4B: {is_letter, letter} = {1'b1, 5'd11};
      8'h3A: {is_letter, letter} = {1'b1, 5'd12};
      8'h31: {is_letter, letter} = {1'b1, 5'd13};
      8'h44: {is_letter, letter} = {1'b1, 5'd14};
      8'h4D: {is_letter, letter} = {1'b1, 5'd15};
      8'h15: {is_letter, letter} = {1'b1, 5'd16};
      8'h2D: {is_letter, letter} = {1'b1, 5'd17};
      8'h1B: {is_letter, letter} = {1'b1, 5'd18};
      8'h2C: {is_letter, letter} = {1'b1, 5'd19};
      8'h3C: {is_letter, letter} = {1'b1, 5'd20};
      8'h2A: {is_letter, letter} = {1'b1, 5'd21};
      8'h1D: {is_letter, letter} = {1'b1, 5'd22};
      8'h22: {is_letter, letter} = {1'b1, 5'd23};
      8'h35: {is_letter, letter} = {1'b1, 5'd24};
      8'h1A: {is_letter, letter} = {1'b1, 5'd25};
      8'h45: {is_digit, digit} = {1'b1, 4'd0};
      8'h16: {is_digit, digit} = {1'b1, 4'd1};
      8'h1E: {is_digit, digit} = {1'b1, 4'd2};
      8'h26: {is_digit, digit} = {1'b1, 4'd3};
      8'h25: {is_digit, digit} = {1'b1, 4'd4};
      8'h2E: {is_digit, digit} = {1'b1, 4'd5};
      8'h36: {is_digit, digit} = {1'b1, 4'd6};
      8'h3D: {is_digit, digit} = {1'b1, 4'd7};
      8'h3E: {is_digit, digit} = {1'b1, 4'd8};
      8'h46: {is_digit, digit} = {1'b1, 4'd9};
      default: ;
    endcase

    if (is_letter) begin
      res.hit  = 1'b1;
      res.code = (upper ? 7'h41 : 7'h61) + CHAR_W'(letter);
    end else if (is_digit) begin
      res.hit  = 1'b1;
      res.code = 7'h30 + CHAR_W'(digit);
      if (sym) begin
        case (digit)
          4'd0:    res.code = 7'h29;
          4'd1:    res.code = 7'h21;
          4'd2:    res.code = 7'h40;
          4'd3:    res.code = 7'h23;
          4'd4:    res.code = 7'h24;
          4'd5:    res.code = 7'h25;
          4'd6:    res.code = 7'h5E;
          4'd7:    res.code = 7'h26;
          4'd8:    res.code = 7'h2A;
          default: res.code = 7'h28;
        endcase
      end
    end else begin
      case (scan)
        SC_BKSP:  res = '{hit: 1'b1, code: CH_DEL};
        SC_ENTER: res = '{hit: 1'b1, code: CH_CR};
        SC_SPACE: res = '{hit: 1'b1, code: CH_SP};
        default:  res = '0;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Scan-byte input, ASCII valid/ready output and key-state signals of the keyboard decoder.
interface ps2_key_decoder_if;
  import ps2_kbd_pkg::*;

  logic [SCAN_W-1:0] scan_code;
  logic              scan_valid;
  logic [CHAR_W-1:0] ascii_code;
  logic              ascii_valid;
  logic              ascii_ready;
  logic              caps_lock;
  logic              shift_held;
  logic              overflow;

  modport master (
    output scan_code, scan_valid, ascii_ready,
    input  ascii_code, ascii_valid, caps_lock, shift_held, overflow
  );

  modport slave (
    input  scan_code, scan_valid, ascii_ready,
    output ascii_code, ascii_valid, caps_lock, shift_held, overflow
  );
endinterface

// File: rtl/kbd_char_fifo.sv
// Small synchronous character FIFO; the head is held in a register so it keeps its
// last value once the FIFO drains.
module kbd_char_fifo #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    rd_ptr_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    remain;
  logic [WIDTH-1:0] rdata_d;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    remain   = count_q - CW'(do_pop);
    count_d  = remain + CW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    rdata_d  = rdata;
    if (remain != '0) begin
      rdata_d = mem_q[rd_ptr_d];
    end else if (do_push) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(do_push);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata    <= rdata_d;
      empty    <= (count_d == '0);
      full     <= (count_d == CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 scan-code decoder: prefix FSM, Shift/Caps tracking, one-entry decode stage
// and an output character FIFO with valid/ready handshake.
module ps2_key_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          SHIFT_SYMBOLS = 1'b1,
  parameter bit          CAPS_INIT     = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  ps2_key_decoder_if.slave  bus
);

  kbd_state_e state_q, state_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       shift_held_q;
  logic       caps_q, caps_d;
  logic       caps_held_q, caps_held_d;
  kbd_char_t  stage_q, stage_d;
  kbd_char_t  lookup;
  logic       overflow_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;

  // Next-state and key-state decode; case/symbol selection uses the pre-byte registers.
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    stage_d     = '0;
    lookup      = scan_to_ascii(bus.scan_code, caps_q ^ shift_held_q,
                                SHIFT_SYMBOLS && shift_held_q);
    if (bus.scan_valid) begin
      if (bus.scan_code == SC_EXT) begin
        state_d = ST_EXT;
      end else if (bus.scan_code == SC_BREAK) begin
        state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ? ST_EXT_BRK : ST_BRK;
      end else if (!(state_q == ST_IDLE && is_idle_noise(bus.scan_code))) begin
        state_d = ST_IDLE;
        case (state_q)
          ST_IDLE: begin
            if (bus.scan_code == SC_LSHIFT) begin
              lshift_d = 1'b1;
            end else if (bus.scan_code == SC_RSHIFT) begin
              rshift_d = 1'b1;
            end else if (bus.scan_code == SC_CAPS) begin
              if (!caps_held_q) begin
                caps_d = ~caps_q;
              end
              caps_held_d = 1'b1;
            end else begin
              stage_d = lookup;
            end
          end
          ST_BRK: begin
            if (bus.scan_code == SC_LSHIFT) begin
              lshift_d = 1'b0;
            end else if (bus.scan_code == SC_RSHIFT) begin
              rshift_d = 1'b0;
            end else if (bus.scan_code == SC_CAPS) begin
              caps_held_d = 1'b0;
            end
          end
          ST_EXT: begin
            if (bus.scan_code == SC_ENTER) begin
              stage_d = '{hit: 1'b1, code: CH_CR};
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      shift_held_q <= 1'b0;
      caps_q       <= CAPS_INIT;
      caps_held_q  <= 1'b0;
      stage_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      shift_held_q <= lshift_d | rshift_d;
      caps_q       <= caps_d;
      caps_held_q  <= caps_held_d;
      stage_q      <= stage_d;
      overflow_q   <= stage_q.hit && fifo_full && !fifo_pop;
    end
  end

  assign fifo_pop = bus.ascii_ready && !fifo_empty;

  kbd_char_fifo #(
    .WIDTH (CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_q.hit),
    .wdata (stage_q.code),
    .pop   (fifo_pop),
    .rdata (bus.ascii_code),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.ascii_valid = ~fifo_empty;
  assign bus.caps_lock   = caps_q;
  assign bus.shift_held  = shift_held_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed key sequences plus random scan traffic, both
// decoder variants (Shift symbols on/off) compared each cycle against a key-level model.
module tb_ps2_key_decoder;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  ps2_key_decoder_if bus();
  ps2_key_decoder_if bus_ns();

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .SHIFT_SYMBOLS(1'b1), .CAPS_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .SHIFT_SYMBOLS(1'b0), .CAPS_INIT(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .bus(bus_ns));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;

  byte unsigned letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                  8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                  8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                  8'h35, 8'h1A};
  byte unsigned digit_sc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46};
  byte unsigned noise_sc[5]  = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};
  string sym_chars = ")!@#$%^&*(";

  // Key-level model: pending prefixes, modifier state, staged character, expected queues.
  bit m_ext, m_brk, m_ls, m_rs, m_caps, m_caps_held, m_ovf;
  bit stg_hit;
  byte unsigned stg_sym, stg_plain;
  byte unsigned q_sym[$];
  byte unsigned q_plain[$];
  byte unsigned last_sym, last_plain;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int map_key(byte unsigned sc, bit upper, bit sym);
    for (int i = 0; i < 26; i++) if (letter_sc[i] == sc) return (upper ? 65 : 97) + i;
    for (int i = 0; i < 10; i++) if (digit_sc[i] == sc) return sym ? int'(sym_chars[i]) : 48 + i;
    case (sc)
      8'h66:   return 127;
      8'h5A:   return 13;
      8'h29:   return 32;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_caps_held = 0; m_ovf = 0;
    stg_hit = 0; stg_sym = 0; stg_plain = 0;
    q_sym.delete(); q_plain.delete();
    last_sym = 0; last_plain = 0;
  endtask

  task automatic model_edge(input byte unsigned b, input bit v, input bit rdy);
    bit pop, up, sh, noise;
    int c1, c0;
    pop = rdy && (q_sym.size() > 0);
    m_ovf = 0;
    if (pop) begin
      void'(q_sym.pop_front());
      void'(q_plain.pop_front());
    end
    if (stg_hit) begin
      if (q_sym.size() < DEPTH) begin
        q_sym.push_back(stg_sym);
        q_plain.push_back(stg_plain);
      end else begin
        m_ovf = 1;
      end
    end
    stg_hit = 0;
    if (v) begin
      sh = m_ls | m_rs;
      up = m_caps ^ sh;
      noise = 0;
      foreach (noise_sc[i]) if (noise_sc[i] == b) noise = 1;
      if (b == 8'hE0) begin
        m_ext = 1; m_brk = 0;
      end else if (b == 8'hF0) begin
        m_brk = 1;
      end else if (m_ext || m_brk || !noise) begin
        if (m_ext) begin
          if (!m_brk && b == 8'h5A) begin stg_hit = 1; stg_sym = 13; stg_plain = 13; end
        end else if (m_brk) begin
          if (b == 8'h12) m_ls = 0;
          else if (b == 8'h59) m_rs = 0;
          else if (b == 8'h58) m_caps_held = 0;
        end else begin
          if (b == 8'h12) m_ls = 1;
          else if (b == 8'h59) m_rs = 1;
          else if (b == 8'h58) begin
            if (!m_caps_held) m_caps = !m_caps;
            m_caps_held = 1;
          end else begin
            c1 = map_key(b, up, sh);
            c0 = map_key(b, up, 1'b0);
            if (c1 >= 0) begin
              stg_hit = 1; stg_sym = 8'(c1); stg_plain = 8'(c0);
            end
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
    if (q_sym.size() > 0) begin
      last_sym = q_sym[0];
      last_plain = q_plain[0];
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", 32'(bus.ascii_valid), 32'(q_sym.size() > 0));
    check_eq("code", 32'(bus.ascii_code), 32'(last_sym));
    check_eq("valid_ns", 32'(bus_ns.ascii_valid), 32'(q_plain.size() > 0));
    check_eq("code_ns", 32'(bus_ns.ascii_code), 32'(last_plain));
    check_eq("caps", 32'(bus.caps_lock), 32'(m_caps));
    check_eq("shift", 32'(bus.shift_held), 32'(m_ls | m_rs));
    check_eq("ovf", 32'(bus.overflow), 32'(m_ovf));
    if (bus.overflow) ovf_seen++;
  endtask

  task automatic drive(input byte unsigned b, input bit v, input bit rdy);
    bus.scan_code = b;    bus.scan_valid = v;    bus.ascii_ready = rdy;
    bus_ns.scan_code = b; bus_ns.scan_valid = v; bus_ns.ascii_ready = rdy;
  endtask

  task automatic step(input byte unsigned b, input bit v, input bit rdy);
    drive(b, v, rdy);
    @(posedge clk);
    model_edge(b, v, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input byte unsigned b);
    step(b, 1'b1, 1'b1);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, rdy);
  endtask

  byte unsigned rb;
  bit rv, rr;

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 32'(bus.ascii_valid), 32'd0);
    check_eq("rst_code", 32'(bus.ascii_code), 32'd0);
    check_eq("rst_caps", 32'(bus.caps_lock), 32'd0);
    check_eq("rst_shift", 32'(bus.shift_held), 32'd0);
    check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;

    // Make latency, then a break produces nothing.
    send(8'h1C);
    check_eq("lat1_valid", 32'(bus.ascii_valid), 32'd0);
    step(8'h00, 1'b0, 1'b1);
    check_eq("lat2_valid", 32'(bus.ascii_valid), 32'd1);
    check_eq("lat2_code", 32'(bus.ascii_code), 32'h61);
    idle(1, 1'b1);
    send(8'hF0); send(8'h1C); idle(3, 1'b1);
    check_eq("brk_none", 32'(bus.ascii_valid), 32'd0);

    // Caps Lock toggles once per press, typematic repeats ignored.
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); idle(1, 1'b1);
    check_eq("caps_on", 32'(bus.caps_lock), 32'd1);
    check_eq("caps_A", 32'(bus.ascii_code), 32'h41);
    send(8'h58); send(8'h58); send(8'h58);
    check_eq("caps_once", 32'(bus.caps_lock), 32'd0);
    send(8'hF0); send(8'h58); idle(2, 1'b1);

    // Shift symbols, and Shift cancelling Caps.
    send(8'h12); send(8'h16); idle(1, 1'b1);
    check_eq("shift_bang", 32'(bus.ascii_code), 32'h21);
    check_eq("shift_one_ns", 32'(bus_ns.ascii_code), 32'h31);
    send(8'h58); send(8'hF0); send(8'h58); send(8'h1C); idle(1, 1'b1);
    check_eq("caps_shift_a", 32'(bus.ascii_code), 32'h61);
    send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58); idle(2, 1'b1);

    // Extended keys.
    send(8'hE0); send(8'h5A); idle(1, 1'b1);
    check_eq("kp_enter", 32'(bus.ascii_code), 32'h0D);
    send(8'h12); send(8'hE0); send(8'hF0); send(8'h12);
    check_eq("ext_shift_kept", 32'(bus.shift_held), 32'd1);
    send(8'hF0); send(8'h12); idle(2, 1'b1);
    send(8'hF0); send(8'hE0); send(8'h75); idle(3, 1'b1);
    check_eq("dangling_brk", 32'(bus.ascii_valid), 32'd0);
    send(8'h1C); idle(1, 1'b1);
    check_eq("back_idle", 32'(bus.ascii_code), 32'h61);
    idle(2, 1'b1);

    // Overflow: DEPTH+1 letters with the consumer stalled, then push with simultaneous pop.
    ovf_seen = 0;
    foreach (letter_sc[i]) if (i < 5) step(letter_sc[i], 1'b1, 1'b0);
    step(8'h2B, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b1);
    idle(2, 1'b0);
    check_eq("ovf_pulses", 32'(ovf_seen), 32'd1);
    check_eq("full_pop_push", 32'(q_sym.size()), 32'(DEPTH));
    idle(8, 1'b1);

    // Async reset mid-sequence with characters queued.
    step(8'h1C, 1'b1, 1'b0); step(8'h32, 1'b1, 1'b0);
    step(8'hE0, 1'b1, 1'b0); step(8'hF0, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    check_eq("pre_rst_valid", 32'(bus.ascii_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", 32'(bus.ascii_valid), 32'd0);
    check_eq("async_valid_ns", 32'(bus_ns.ascii_valid), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    send(8'h1C); idle(1, 1'b1);
    check_eq("post_rst_a", 32'(bus.ascii_code), 32'h61);
    idle(2, 1'b1);

    // Random scan traffic with random back-pressure.
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5: rb = letter_sc[$urandom_range(0, 25)];
        6, 7:             rb = digit_sc[$urandom_range(0, 9)];
        8:                rb = 8'h12;
        9:                rb = 8'h59;
        10:               rb = 8'h58;
        11, 12, 13:       rb = 8'hF0;
        14:               rb = 8'hE0;
        15:               rb = 8'h5A;
        16:               rb = ($urandom_range(0, 1) != 0) ? 8'h66 : 8'h29;
        17:               rb = noise_sc[$urandom_range(0, 4)];
        default:          rb = 8'($urandom());
      endcase
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      step(rb, rv, rr);
    end
    idle(10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
